log2: RTL and testbench

LOG2 -- requirements
Module: log2

---
 rtl/log2.sv | 114 +++++++++++
 tb/tb_log2.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/log2.sv
// Sequential fixed-point log2: 3-bit integer part from the leading one, 5 fraction
// bits by square-and-compare. Optional zero_err output is enabled by LOG2_ZERO_ERR_EN.
module log2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       h,
  input  logic [7:0] in,
`ifdef LOG2_ZERO_ERR_EN
  output logic       zero_err,
`endif
  output logic       flag,
  output logic [7:0] out
);

  localparam int unsigned MANT_W = 24;
  localparam int unsigned PROD_W = 2 * MANT_W;
  localparam int unsigned SQ_W   = MANT_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] FRAC = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [7:0]        opnd, opnd_nxt;
  logic [2:0]        ipart, ipart_nxt;
  logic [MANT_W-1:0] mant, mant_nxt;
  logic [4:0]        frac, frac_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [7:0]        out_nxt;
  logic              flag_nxt;
  logic [2:0]        msb;
  logic [PROD_W-1:0] prod;
  logic [SQ_W-1:0]   sq;

  // Leading-one position of the captured operand (0 for a zero operand).
  always_comb begin
    msb = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (opnd[i]) msb = 3'(i);
    end
  end

  // Mantissa square in 1.23 format, truncated back to 2.23.
  assign prod = PROD_W'(mant) * PROD_W'(mant);
  assign sq   = SQ_W'(prod >> (MANT_W - 1));

  always_comb begin
    state_nxt = state;
    opnd_nxt  = opnd;
    ipart_nxt = ipart;
    mant_nxt  = mant;
    frac_nxt  = frac;
    cnt_nxt   = cnt;
    out_nxt   = out;
    case (state)
      IDLE: begin
        if (h) begin
          opnd_nxt  = in;
          state_nxt = NORM;
        end
      end
      NORM: begin
        ipart_nxt = msb;
        mant_nxt  = {8'(opnd << (3'd7 - msb)), 16'd0};
        frac_nxt  = 5'd0;
        cnt_nxt   = 3'd0;
        state_nxt = FRAC;
      end
      FRAC: begin
        frac_nxt = {frac[3:0], sq[SQ_W-1]};
        mant_nxt = sq[SQ_W-1] ? sq[SQ_W-1:1] : sq[MANT_W-1:0];
        cnt_nxt  = cnt + 3'd1;
        if (cnt == 3'd4) begin
          out_nxt   = {ipart, frac[3:0], sq[SQ_W-1]};
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    flag_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      opnd  <= 8'd0;
      ipart <= 3'd0;
      mant  <= '0;
      frac  <= 5'd0;
      cnt   <= 3'd0;
      out   <= 8'h00;
      flag  <= 1'b0;
    end else begin
      state <= state_nxt;
      opnd  <= opnd_nxt;
      ipart <= ipart_nxt;
      mant  <= mant_nxt;
      frac  <= frac_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      flag  <= flag_nxt;
    end
  end

`ifdef LOG2_ZERO_ERR_EN
  // Pulses with flag when the finished operand was zero.
  always_ff @(posedge clk) begin
    if (reset) zero_err <= 1'b0;
    else       zero_err <= (state_nxt == DONE) && (opnd == 8'd0);
  end
`endif

endmodule

// File: tb/tb_log2.sv
// Scoreboard bench for log2: stimulus pushes expected results, a monitor pops on flag.
module tb_log2;

  logic       clk = 1'b0;
  logic       reset;
  logic       h;
  logic [7:0] in;
  logic       flag;
  logic [7:0] out;
`ifdef LOG2_ZERO_ERR_EN
  logic       zero_err;
`endif

  log2 dut (
    .clk      (clk),
    .reset    (reset),
    .h        (h),
    .in       (in),
`ifdef LOG2_ZERO_ERR_EN
    .zero_err (zero_err),
`endif
    .flag     (flag),
    .out      (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       zerr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  logic prev_flag = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // Independent reference: floor(32*log2(x)) is the leading-one index of x**32.
  function automatic logic [7:0] ref_log2(input int x);
    logic [263:0] p;
    int r;
    p = 264'(x);
    for (int k = 0; k < 5; k++) p = p * p;
    r = 0;
    for (int i = 0; i < 264; i++) if (p[i]) r = i;
    return 8'(r);
  endfunction

  task automatic push(input logic [7:0] v, input logic [7:0] want);
    exp_t e;
    e.res  = want;
    e.zerr = (v == 8'd0);
    exp_q.push_back(e);
  endtask

  // Monitor: pop on every flag, and check each flag pulse lasts one cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_flag) chk("flag_width", int'(flag), 0);
      if (flag) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flag", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out", int'(out), int'(e.res));
`ifdef LOG2_ZERO_ERR_EN
          chk("zero_err", int'(zero_err), int'(e.zerr));
`endif
        end
      end
      prev_flag <= flag;
    end else begin
      prev_flag <= 1'b0;
    end
  end

  // Capture one operand, then measure edges until flag (capture edge = 1).
  task automatic run_one(input logic [7:0] v, input logic [7:0] want);
    int n;
    @(negedge clk);
    in = v;
    h  = 1'b1;
    push(v, want);
    @(posedge clk);
    @(negedge clk);
    h = 1'b0;
    n = 1;
    while (!flag && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", n, 7);
    @(posedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    h     = 1'b0;
    in    = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out", int'(out), 0);
    chk("reset_flag", int'(flag), 0);
`ifdef LOG2_ZERO_ERR_EN
    chk("reset_zero_err", int'(zero_err), 0);
`endif
    reset = 1'b0;

    run_one(8'd1,   8'h00);
    run_one(8'd2,   8'h20);
    run_one(8'd3,   8'h32);
    run_one(8'd5,   8'h4A);
    run_one(8'd128, 8'hE0);
    run_one(8'd255, 8'hFF);
    run_one(8'd0,   8'h00);

    // Operand changes after capture must not disturb the result.
    @(negedge clk);
    in = 8'd3;
    h  = 1'b1;
    push(8'd3, 8'h32);
    @(posedge clk);
    @(negedge clk);
    h = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in = 8'd200;
    n = 0;
    while (!flag && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("hold_in_flag_seen", int'(flag), 1);
    @(posedge clk);

    // Reset in the middle of FRAC aborts the operation without a flag.
    run_one(8'd5, 8'h4A);
    @(negedge clk);
    in = 8'd9;
    h  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    h = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_flag", int'(flag), 0);
    chk("abort_out", int'(out), 0);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    run_one(8'd6, 8'h52);

    // Exhaustive back-to-back sweep with h held high.
    for (int v = 0; v < 256; v++) begin
      @(negedge clk);
      in = 8'(v);
      h  = 1'b1;
      push(8'(v), ref_log2(v));
      repeat (8) @(posedge clk);
    end
    @(negedge clk);
    h = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
